// File: rtl/codificador_instruccion_pkg.sv
// Shared types and constants for the RV32I instruction encoder (package codif_pkg).
// The optional U/J support is enabled in the design by defining CODIF_UJ_EN.
package codif_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [31:0] OPC_NOP = 32'h00000013;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

  // fmt is kept as raw bits because codes 6 and 7 must travel through S1 to be flagged
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } campos_t;

  function automatic logic en_rango(input logic signed [31:0] v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/codificador_instruccion_empaquetador_imm.sv
// Combinational immediate placer: scatters imm bits into their RV32I slots and flags
// out-of-range/misaligned immediates or unsupported formats. U/J enabled by CODIF_UJ_EN.
module empaquetador_imm
  import codif_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [31:0] i_imm,
  output logic [31:0] o_imm_bits,
  output logic        o_err_imm,
  output logic        o_err_fmt
);

  logic signed [31:0] w_imm_s;

  assign w_imm_s = i_imm;

  // Out-of-range immediates still get their truncated bits packed; only the flag changes
  always_comb begin
    o_imm_bits = '0;
    o_err_imm  = 1'b0;
    o_err_fmt  = 1'b0;
    case (i_fmt)
      FMT_R: ;
      FMT_I: begin
        o_imm_bits[31:20] = i_imm[11:0];
        o_err_imm         = !en_rango(w_imm_s, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        o_imm_bits[31:25] = i_imm[11:5];
        o_imm_bits[11:7]  = i_imm[4:0];
        o_err_imm         = !en_rango(w_imm_s, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        o_imm_bits[31:25] = {i_imm[12], i_imm[10:5]};
        o_imm_bits[11:7]  = {i_imm[4:1], i_imm[11]};
        o_err_imm         = !en_rango(w_imm_s, IMM13_MIN, IMM13_MAX) || i_imm[0];
      end
`ifdef CODIF_UJ_EN
      FMT_U: begin
        o_imm_bits[31:12] = i_imm[31:12];
        o_err_imm         = |i_imm[11:0];
      end
      FMT_J: begin
        o_imm_bits[31:12] = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12]};
        o_err_imm         = !en_rango(w_imm_s, IMM21_MIN, IMM21_MAX) || i_imm[0];
      end
`endif
      default: o_err_fmt = 1'b1;
    endcase
  end

endmodule

// File: rtl/codificador_instruccion.sv
// Two-stage RV32I instruction encoder feeding IMEM over valid/ready with a running byte
// address. Define CODIF_UJ_EN to encode U and J formats; otherwise they emit NOP + err_fmt.
module codificador_instruccion
  import codif_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instruccion,
  output logic [ADDR_W-1:0] direccion,
  output logic              err_imm,
  output logic              err_fmt,
  output logic              err_sticky
);

  localparam logic [ADDR_W-1:0] DIR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] DIR_PASO = ADDR_W'(4);

  logic              r_s1_v;
  campos_t           r_s1;
  logic              r_out_valid;
  logic [31:0]       r_instruccion;
  logic [ADDR_W-1:0] r_direccion;
  logic              r_err_imm;
  logic              r_err_fmt;
  logic              r_err_sticky;

  logic              w_s2_load;
  logic [31:0]       w_imm_bits;
  logic              w_err_imm;
  logic              w_err_fmt;
  logic [31:0]       w_campos;
  logic [31:0]       w_palabra;

  assign w_s2_load   = !r_out_valid || out_ready;
  assign in_ready    = !r_s1_v || w_s2_load;
  assign out_valid   = r_out_valid;
  assign instruccion = r_instruccion;
  assign direccion   = r_direccion;
  assign err_imm     = r_err_imm;
  assign err_fmt     = r_err_fmt;
  assign err_sticky  = r_err_sticky;

  empaquetador_imm u_empaquetador (
    .i_fmt      (r_s1.fmt),
    .i_imm      (r_s1.imm),
    .o_imm_bits (w_imm_bits),
    .o_err_imm  (w_err_imm),
    .o_err_fmt  (w_err_fmt)
  );

  // Register fields per format; an illegal format overrides the whole word with NOP
  always_comb begin
    w_campos = '0;
    case (r_s1.fmt)
      FMT_R:        w_campos = {r_s1.funct7, r_s1.rs2, r_s1.rs1, r_s1.funct3, r_s1.rd, r_s1.opcode};
      FMT_I:        w_campos = {12'b0, r_s1.rs1, r_s1.funct3, r_s1.rd, r_s1.opcode};
      FMT_S, FMT_B: w_campos = {7'b0, r_s1.rs2, r_s1.rs1, r_s1.funct3, 5'b0, r_s1.opcode};
      FMT_U, FMT_J: w_campos = {20'b0, r_s1.rd, r_s1.opcode};
      default:      w_campos = '0;
    endcase
    w_palabra = w_err_fmt ? OPC_NOP : (w_campos | w_imm_bits);
  end

  // clr beats any handshake on the same edge, so a dropped word never advances direccion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v        <= 1'b0;
      r_s1          <= '0;
      r_out_valid   <= 1'b0;
      r_instruccion <= '0;
      r_direccion   <= DIR_BASE;
      r_err_imm     <= 1'b0;
      r_err_fmt     <= 1'b0;
      r_err_sticky  <= 1'b0;
    end else if (clr) begin
      r_s1_v       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_direccion  <= DIR_BASE;
      r_err_sticky <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_v <= in_valid;
        if (in_valid) begin
          r_s1 <= '{fmt: in_fmt, opcode: in_opcode, funct3: in_funct3, funct7: in_funct7,
                    rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
        end
      end
      if (w_s2_load) begin
        r_out_valid <= r_s1_v;
        if (r_s1_v) begin
          r_instruccion <= w_palabra;
          r_err_imm     <= w_err_imm;
          r_err_fmt     <= w_err_fmt;
        end
      end
      if (r_out_valid && out_ready) begin
        r_direccion  <= r_direccion + DIR_PASO;
        r_err_sticky <= r_err_sticky | r_err_imm | r_err_fmt;
      end
    end
  end

endmodule

// File: tb/tb_codificador_instruccion.sv
// Directed self-checking bench for codificador_instruccion; U/J vectors follow CODIF_UJ_EN.
`timescale 1ns/1ps
module tb_codificador_instruccion;
  import codif_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst, clr, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]        in_fmt, in_funct3;
  logic [6:0]        in_opcode, in_funct7;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [31:0]       in_imm, instruccion;
  logic [ADDR_W-1:0] direccion;
  logic              err_imm, err_fmt, err_sticky;

  int                nChecks = 0;
  int                nPass   = 0;
  logic [ADDR_W-1:0] expAddr = '0;
  logic              expSticky = 1'b0;

  codificador_instruccion #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruccion(instruccion), .direccion(direccion),
    .err_imm(err_imm), .err_fmt(err_fmt), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed === expected) nPass++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic setFields(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Offer one bundle from a falling edge until accepted, then drop in_valid
  task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm);
    int n = 0;
    setFields(fmt, op, f3, f7, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for the next word, compare it with the model, then let it handshake
  task automatic checkWord(input string tag, input logic [31:0] expInstr,
                           input logic expErrImm, input logic expErrFmt);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"},  32'(out_valid), 32'd1);
    checkOutput({tag, "_instr"},  instruccion, expInstr);
    checkOutput({tag, "_addr"},   32'(direccion), 32'(expAddr));
    checkOutput({tag, "_errimm"}, 32'(err_imm), 32'(expErrImm));
    checkOutput({tag, "_errfmt"}, 32'(err_fmt), 32'(expErrFmt));
    checkOutput({tag, "_sticky"}, 32'(err_sticky), 32'(expSticky));
    @(posedge clk);
    expAddr   = expAddr + ADDR_W'(4);
    expSticky = expSticky | expErrImm | expErrFmt;
    @(negedge clk);
  endtask

  task automatic sendAndCheck(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                              input logic [31:0] expInstr, input logic expErrImm, input logic expErrFmt);
    applyStimulus(fmt, op, f3, f7, rd, rs1, rs2, imm);
    checkWord(tag, expInstr, expErrImm, expErrFmt);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    setFields(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready",  32'(in_ready), 32'd1);
    checkOutput("rst_instr",     instruccion, 32'd0);
    checkOutput("rst_addr",      32'(direccion), 32'd0);
    checkOutput("rst_errs",      32'({err_imm, err_fmt, err_sticky}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First word: one cycle in S1 before it shows up
    setFields(FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat_now", 32'(out_valid), 32'd1);
    checkWord("addi", 32'h00500093, 1'b0, 1'b0);

    sendAndCheck("sw",      FMT_S, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423, 1'b0, 1'b0);
    sendAndCheck("beq_m4",  FMT_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4,      32'hFE000EE3, 1'b0, 1'b0);
    sendAndCheck("beq_4096",FMT_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4096,     32'h80000063, 1'b1, 1'b0);
    checkOutput("sticky_set", 32'(err_sticky), 32'd1);
    sendAndCheck("i_2047",  FMT_I, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2047,     32'h7FF00013, 1'b0, 1'b0);
    sendAndCheck("i_2048",  FMT_I, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2048,     32'h80000013, 1'b1, 1'b0);
    sendAndCheck("i_m2048", FMT_I, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd2048,   32'h80000013, 1'b0, 1'b0);
    sendAndCheck("i_m2049", FMT_I, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd2049,   32'h7FF00013, 1'b1, 1'b0);
    sendAndCheck("b_4094",  FMT_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4094,     32'h7E000FE3, 1'b0, 1'b0);
    sendAndCheck("b_m4096", FMT_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4096,   32'h80000063, 1'b0, 1'b0);
    sendAndCheck("b_odd",   FMT_B, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd5,        32'h00000263, 1'b1, 1'b0);
    sendAndCheck("r_add",   FMT_R, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'hFFFFFFFF, 32'h002081B3, 1'b0, 1'b0);
    sendAndCheck("r_sub",   FMT_R, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'hFFFFFFFF, 32'h402081B3, 1'b0, 1'b0);
    sendAndCheck("fmt7",    3'd7,  7'h33, 3'd1, 7'h20, 5'd3, 5'd1, 5'd2, 32'hFFFFFFFF, 32'h00000013, 1'b0, 1'b1);
    sendAndCheck("fmt6",    3'd6,  7'h63, 3'd0, 7'd0,  5'd3, 5'd1, 5'd2, 32'd4096,     32'h00000013, 1'b0, 1'b1);
`ifdef CODIF_UJ_EN
    sendAndCheck("lui",     FMT_U, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0, 1'b0);
    sendAndCheck("jal",     FMT_J, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8,        32'h008000EF, 1'b0, 1'b0);
`else
    sendAndCheck("lui",     FMT_U, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h00000013, 1'b0, 1'b1);
    sendAndCheck("jal",     FMT_J, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8,        32'h00000013, 1'b0, 1'b1);
`endif

    // Back-pressure: three bundles offered while IMEM stalls for three edges
    out_ready = 1'b0;
    setFields(FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("stall_rdy_first", 32'(in_ready), 32'd1);
    setFields(FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2);
    @(posedge clk);
    @(negedge clk);
    checkOutput("stall_rdy_low", 32'(in_ready), 32'd0);
    checkOutput("stall_a_instr", instruccion, 32'h00100093);
    checkOutput("stall_a_addr",  32'(direccion), 32'(expAddr));
    setFields(FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
    @(posedge clk);
    @(negedge clk);
    checkOutput("stall_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_hold_instr", instruccion, 32'h00100093);
    checkOutput("stall_hold_addr",  32'(direccion), 32'(expAddr));
    checkOutput("stall_hold_errs",  32'({err_imm, err_fmt}), 32'd0);
    checkOutput("stall_hold_rdy",   32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    expAddr = expAddr + ADDR_W'(4);
    checkWord("stall_b", 32'h00200093, 1'b0, 1'b0);
    checkWord("stall_c", 32'h00300093, 1'b0, 1'b0);
    checkOutput("stall_drained", 32'(out_valid), 32'd0);

    // Flush with two words in flight while both handshakes would otherwise fire
    checkOutput("pre_clr_sticky", 32'(err_sticky), 32'd1);
    out_ready = 1'b0;
    setFields(FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    setFields(FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
    @(posedge clk);
    @(negedge clk);
    setFields(FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd9);
    out_ready = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    checkOutput("clr_valid",  32'(out_valid), 32'd0);
    checkOutput("clr_addr",   32'(direccion), 32'd0);
    checkOutput("clr_sticky", 32'(err_sticky), 32'd0);
    @(negedge clk);
    checkOutput("clr_empty", 32'(out_valid), 32'd0);
    expAddr = '0;
    expSticky = 1'b0;
    sendAndCheck("post_clr", FMT_I, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0, 1'b0);

    // Asynchronous reset between edges with a stalled word pending
    out_ready = 1'b0;
    applyStimulus(FMT_S, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    @(negedge clk);
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_instr", instruccion, 32'd0);
    checkOutput("arst_addr",  32'(direccion), 32'd0);
    checkOutput("arst_ready", 32'(in_ready), 32'd1);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("arst_no_partial", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
